// File: rtl/ag_stage_ctrl.sv
// ag_stage_ctrl: sequencing controller for the address-generation stage.
// Owns the AG->ME valid flop and latch enable and drives the stall to decode.
// It splits an IDT-entry read into a low-dword slot and a high-dword slot.
// A segment-limit fault becomes an exception bubble, and the stage then
// blocks until writeback flushes it. It also keeps a saturating count of the
// cycles in which it stalls decode.
module ag_stage_ctrl #(
  parameter int          CNT_W        = 16,
  parameter logic [3:0]  SEG_EXC_CODE = 4'd13
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             V,
  input  logic             DEP_STALL,
  input  logic             SEG_LIMIT_EXC,
  input  logic             CS_IDT_RD,
  input  logic [3:0]       DE_EXC_CODE_AG,
  input  logic             ME_STALL,
  input  logic             FLUSH,
  output logic             LD_AG_ME,
  output logic             STALL_DE,
  output logic             V_ME,
  output logic             EXC_ME,
  output logic [3:0]       EXC_CODE_ME,
  output logic             IDT_PHASE_ME,
  output logic [CNT_W-1:0] STALL_CNT
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_IDT_HI   = 2'd1,
    ST_EXC_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_r;
  state_t     state_nxt_s;
  logic       ld_s;
  logic       stall_de_s;
  logic       v_me_nxt_s;
  logic       exc_me_nxt_s;
  logic [3:0] exc_code_nxt_s;
  logic       idt_phase_nxt_s;

  assign LD_AG_ME = ld_s;
  assign STALL_DE = stall_de_s;

  // State register; the unused encoding is steered back to RUN by next-state logic.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection: flush wins, an ME stall freezes, otherwise sequence.
  always_comb begin
    state_nxt_s = state_r;
    if (FLUSH) begin
      state_nxt_s = ST_RUN;
    end else if (ME_STALL) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (V && !DEP_STALL && SEG_LIMIT_EXC) begin
            state_nxt_s = ST_EXC_WAIT;
          end else if (V && !DEP_STALL && CS_IDT_RD) begin
            state_nxt_s = ST_IDT_HI;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_IDT_HI:   state_nxt_s = ST_RUN;
        ST_EXC_WAIT: state_nxt_s = ST_EXC_WAIT;
        default:     state_nxt_s = ST_RUN;
      endcase
    end
  end

  // Output decode: latch enable, decode stall and the next ME entry contents.
  always_comb begin
    ld_s            = 1'b1;
    stall_de_s      = 1'b0;
    v_me_nxt_s      = V_ME;
    exc_me_nxt_s    = EXC_ME;
    exc_code_nxt_s  = EXC_CODE_ME;
    idt_phase_nxt_s = IDT_PHASE_ME;
    if (FLUSH) begin
      v_me_nxt_s      = 1'b0;
      exc_me_nxt_s    = 1'b0;
      idt_phase_nxt_s = 1'b0;
    end else if (ME_STALL) begin
      // ME holds its entry; decode must wait if AG still has work in flight.
      ld_s       = 1'b0;
      stall_de_s = V | (state_r != ST_RUN);
    end else begin
      case (state_r)
        ST_RUN: begin
          if (!V) begin
            v_me_nxt_s      = 1'b0;
            exc_me_nxt_s    = 1'b0;
            idt_phase_nxt_s = 1'b0;
          end else if (DEP_STALL) begin
            // Dependency bubble masks any fault or IDT request on this instruction.
            stall_de_s      = 1'b1;
            v_me_nxt_s      = 1'b0;
            exc_me_nxt_s    = 1'b0;
            idt_phase_nxt_s = 1'b0;
          end else if (SEG_LIMIT_EXC) begin
            stall_de_s      = 1'b1;
            v_me_nxt_s      = 1'b1;
            exc_me_nxt_s    = 1'b1;
            exc_code_nxt_s  = SEG_EXC_CODE;
            idt_phase_nxt_s = 1'b0;
          end else if (CS_IDT_RD) begin
            // Low dword goes now; the instruction stays in AG for the high dword.
            stall_de_s      = 1'b1;
            v_me_nxt_s      = 1'b1;
            exc_me_nxt_s    = 1'b0;
            exc_code_nxt_s  = DE_EXC_CODE_AG;
            idt_phase_nxt_s = 1'b0;
          end else begin
            v_me_nxt_s      = 1'b1;
            exc_me_nxt_s    = 1'b0;
            exc_code_nxt_s  = DE_EXC_CODE_AG;
            idt_phase_nxt_s = 1'b0;
          end
        end
        ST_IDT_HI: begin
          // High dword slot; decode is released so the next instruction enters.
          v_me_nxt_s      = 1'b1;
          exc_me_nxt_s    = 1'b0;
          idt_phase_nxt_s = 1'b1;
        end
        ST_EXC_WAIT: begin
          stall_de_s   = 1'b1;
          v_me_nxt_s   = 1'b0;
          exc_me_nxt_s = 1'b0;
        end
        default: begin
          v_me_nxt_s      = 1'b0;
          exc_me_nxt_s    = 1'b0;
          idt_phase_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // AG->ME pipeline flops (valid, exception flag, code, IDT phase).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      V_ME         <= 1'b0;
      EXC_ME       <= 1'b0;
      EXC_CODE_ME  <= 4'd0;
      IDT_PHASE_ME <= 1'b0;
    end else begin
      V_ME         <= v_me_nxt_s;
      EXC_ME       <= exc_me_nxt_s;
      EXC_CODE_ME  <= exc_code_nxt_s;
      IDT_PHASE_ME <= idt_phase_nxt_s;
    end
  end

  // Saturating count of cycles in which decode is stalled.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      STALL_CNT <= {CNT_W{1'b0}};
    end else if (stall_de_s && (STALL_CNT != CNT_MAX)) begin
      STALL_CNT <= STALL_CNT + CNT_ONE;
    end else begin
      STALL_CNT <= STALL_CNT;
    end
  end

endmodule

// File: tb/tb_ag_stage_ctrl.sv
// Self-checking bench for ag_stage_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_ag_stage_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       V, DEP_STALL, SEG_LIMIT_EXC, CS_IDT_RD, ME_STALL, FLUSH;
  logic [3:0] DE_EXC_CODE_AG;
  logic       LD_AG_ME, STALL_DE, V_ME, EXC_ME, IDT_PHASE_ME;
  logic [3:0] EXC_CODE_ME;
  logic [15:0] STALL_CNT;
  logic       s_ld, s_sd, s_v, s_exc, s_phase;
  logic [3:0] s_code;
  logic [1:0] s_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: ME slot contents, pending work and stall counts.
  bit         m_v, m_exc, m_phase, m_code_known;
  logic [3:0] m_code;
  bit         m_hi_pending;   // IDT high dword still owed to ME
  bit         m_blocked;      // exception issued, waiting for flush
  int         m_cnt, m_cnt2;

  ag_stage_ctrl dut (
    .CLK(CLK), .RST(RST), .V(V), .DEP_STALL(DEP_STALL),
    .SEG_LIMIT_EXC(SEG_LIMIT_EXC), .CS_IDT_RD(CS_IDT_RD),
    .DE_EXC_CODE_AG(DE_EXC_CODE_AG), .ME_STALL(ME_STALL), .FLUSH(FLUSH),
    .LD_AG_ME(LD_AG_ME), .STALL_DE(STALL_DE), .V_ME(V_ME), .EXC_ME(EXC_ME),
    .EXC_CODE_ME(EXC_CODE_ME), .IDT_PHASE_ME(IDT_PHASE_ME), .STALL_CNT(STALL_CNT)
  );

  ag_stage_ctrl #(.CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .V(V), .DEP_STALL(DEP_STALL),
    .SEG_LIMIT_EXC(SEG_LIMIT_EXC), .CS_IDT_RD(CS_IDT_RD),
    .DE_EXC_CODE_AG(DE_EXC_CODE_AG), .ME_STALL(ME_STALL), .FLUSH(FLUSH),
    .LD_AG_ME(s_ld), .STALL_DE(s_sd), .V_ME(s_v), .EXC_ME(s_exc),
    .EXC_CODE_ME(s_code), .IDT_PHASE_ME(s_phase), .STALL_CNT(s_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v = 1'b0; m_exc = 1'b0; m_phase = 1'b0; m_code = 4'd0; m_code_known = 1'b0;
    m_hi_pending = 1'b0; m_blocked = 1'b0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // One clock cycle: apply inputs, compare at the falling edge, advance model.
  task automatic step(input bit fl, input bit ms, input bit v, input bit dep,
                      input bit seg, input bit idt, input logic [3:0] code);
    bit e_ld, e_sd;
    FLUSH = fl; ME_STALL = ms; V = v; DEP_STALL = dep;
    SEG_LIMIT_EXC = seg; CS_IDT_RD = idt; DE_EXC_CODE_AG = code;
    @(negedge CLK);
    e_ld = 1'b1;
    e_sd = 1'b0;
    if (fl) begin
      e_sd = 1'b0;
    end else if (ms) begin
      e_ld = 1'b0;
      e_sd = v || m_hi_pending || m_blocked;
    end else if (m_hi_pending) begin
      e_sd = 1'b0;
    end else if (m_blocked) begin
      e_sd = 1'b1;
    end else begin
      e_sd = v && (dep || seg || idt);
    end
    chk("LD_AG_ME", LD_AG_ME, e_ld);
    chk("STALL_DE", STALL_DE, e_sd);
    chk("V_ME", V_ME, m_v);
    if (m_v) begin
      chk("EXC_ME", EXC_ME, m_exc);
      chk("IDT_PHASE_ME", IDT_PHASE_ME, m_phase);
      if (m_code_known) chk("EXC_CODE_ME", EXC_CODE_ME, m_code);
    end
    chk("STALL_CNT", STALL_CNT, m_cnt);
    chk("STALL_CNT_W2", s_cnt, m_cnt2);
    // advance model
    if (e_sd) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (fl) begin
      m_v = 0; m_exc = 0; m_phase = 0; m_hi_pending = 0; m_blocked = 0;
    end else if (ms) begin
      // ME keeps its entry; nothing moves
    end else if (m_hi_pending) begin
      m_v = 1; m_exc = 0; m_phase = 1; m_hi_pending = 0;
    end else if (m_blocked) begin
      m_v = 0; m_exc = 0;
    end else if (!v || dep) begin
      m_v = 0; m_exc = 0;
    end else if (seg) begin
      m_v = 1; m_exc = 1; m_phase = 0; m_code = 4'd13; m_code_known = 1; m_blocked = 1;
    end else if (idt) begin
      m_v = 1; m_exc = 0; m_phase = 0; m_code = code; m_code_known = 1; m_hi_pending = 1;
    end else begin
      m_v = 1; m_exc = 0; m_phase = 0; m_code_known = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    FLUSH = 0; ME_STALL = 0; V = 0; DEP_STALL = 0;
    SEG_LIMIT_EXC = 0; CS_IDT_RD = 0; DE_EXC_CODE_AG = 4'd0;
    RST = 1'b0;
    #1;
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    RST = 1'b0;
    FLUSH = 0; ME_STALL = 0; V = 0; DEP_STALL = 0;
    SEG_LIMIT_EXC = 0; CS_IDT_RD = 0; DE_EXC_CODE_AG = 4'd0;
    model_reset();
    #2;
    chk("rst_V_ME", V_ME, 1'b0);
    chk("rst_EXC_ME", EXC_ME, 1'b0);
    chk("rst_CODE", EXC_CODE_ME, 4'd0);
    chk("rst_PHASE", IDT_PHASE_ME, 1'b0);
    chk("rst_CNT", STALL_CNT, 16'd0);
    chk("rst_LD", LD_AG_ME, 1'b1);
    chk("rst_STALL_DE", STALL_DE, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Reset in the middle of an IDT sequence
    step(0, 0, 1, 0, 0, 1, 4'd8);
    chk("mididt_pre_V", V_ME, 1'b1);
    chk("mididt_pre_CNT", STALL_CNT, 16'd1);
    #1;
    RST = 1'b0;
    #1;
    chk("mididt_V_ME", V_ME, 1'b0);
    chk("mididt_PHASE", IDT_PHASE_ME, 1'b0);
    chk("mididt_CNT", STALL_CNT, 16'd0);
    model_reset();
    V = 0; CS_IDT_RD = 0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    step(0, 0, 0, 0, 0, 0, 4'd0);
    chk("mididt_after_V_ME", V_ME, 1'b0);

    // Back-to-back issue
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 0, 4'(i));
      chk("b2b_V_ME", V_ME, 1'b1);
    end
    chk("b2b_CNT", STALL_CNT, 16'd0);

    // Dependency bubbles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 1, 1, 4'd3);
      chk("dep_V_ME", V_ME, 1'b0);
    end
    chk("dep_CNT", STALL_CNT, 16'd3);
    step(0, 0, 1, 0, 0, 0, 4'd3);
    chk("dep_issue_V_ME", V_ME, 1'b1);

    // IDT read with an ME stall between the two phases
    do_reset();
    step(0, 0, 1, 0, 0, 1, 4'd8);
    chk("idt_lo_V", V_ME, 1'b1);
    chk("idt_lo_PHASE", IDT_PHASE_ME, 1'b0);
    chk("idt_lo_CODE", EXC_CODE_ME, 4'd8);
    step(0, 1, 1, 0, 0, 1, 4'd8);
    chk("idt_hold_V", V_ME, 1'b1);
    chk("idt_hold_PHASE", IDT_PHASE_ME, 1'b0);
    step(0, 0, 1, 0, 0, 1, 4'd8);
    chk("idt_hi_PHASE", IDT_PHASE_ME, 1'b1);
    chk("idt_hi_CODE", EXC_CODE_ME, 4'd8);
    chk("idt_CNT", STALL_CNT, 16'd2);
    step(0, 0, 0, 0, 0, 0, 4'd0);

    // Segment fault, blocking until flush
    do_reset();
    step(0, 0, 1, 0, 1, 1, 4'd5);
    chk("seg_EXC", EXC_ME, 1'b1);
    chk("seg_CODE", EXC_CODE_ME, 4'd13);
    chk("seg_PHASE", IDT_PHASE_ME, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 1, 0, 4'd5);
      chk("seg_wait_V", V_ME, 1'b0);
    end
    chk("seg_wait_CNT", STALL_CNT, 16'd6);
    step(1, 0, 1, 0, 1, 0, 4'd5);
    step(0, 0, 1, 0, 0, 0, 4'd1);
    chk("seg_after_flush_V", V_ME, 1'b1);
    chk("seg_after_flush_CNT", STALL_CNT, 16'd6);

    // Saturation of the 2-bit counter
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 1, 0, 0, 4'd0);
      chk("sat_CNT", s_cnt, (i < 3) ? 2'(i + 1) : 2'd3);
    end

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 15,
           4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ag_stage_ctrl.md
Name: ag_stage_ctrl

Overview:
- Sequencing controller for the address-generation (AG) stage. It owns the AG->ME pipeline valid flop and the AG->ME latch-enable, and it drives the stall back to decode.
- It splits an IDT-entry read into two memory phases (low dword, then high dword), turns segment-limit faults into an exception bubble, and holds the pipe until writeback flushes it.
- It keeps a saturating count of AG stall cycles for performance monitoring.

Parameters:
- CNT_W, 16, width of the stall-cycle counter.
- SEG_EXC_CODE, 4'd13, exception code raised on a segment-limit fault.

Ports:
- CLK  in  1  stage clock.
- RST  in  1  asynchronous reset, active-low.
- V  in  1  AG latch holds a valid instruction.
- DEP_STALL  in  1  register dependency unresolved.
- SEG_LIMIT_EXC  in  1  segment-limit violation on this instruction.
- CS_IDT_RD  in  1  microcode requests an IDT-entry read (2 phases).
- DE_EXC_CODE_AG  in  4  exception vector carried by the instruction.
- ME_STALL  in  1  ME stage cannot accept a new entry this cycle.
- FLUSH  in  1  writeback flush (branch/exception commit).
- LD_AG_ME  out  1  comb: load enable for all AG->ME data latches.
- STALL_DE  out  1  comb: hold the DE->AG latch.
- V_ME  out  1  reg: valid bit of the ME latch.
- EXC_ME  out  1  reg: ME entry is an exception bubble.
- EXC_CODE_ME  out  4  reg: exception code of the ME entry.
- IDT_PHASE_ME  out  1  reg: 0 = IDT low dword (+0), 1 = high dword (+4).
- STALL_CNT  out  CNT_W  reg: saturating count of cycles with STALL_DE=1.

Behaviour:
- Reset (RST=0, async): state=RUN; V_ME=0, EXC_ME=0, EXC_CODE_ME=0, IDT_PHASE_ME=0, STALL_CNT=0. With V=0 the comb outputs are LD_AG_ME=1 and STALL_DE=0.
- States: RUN, IDT_HI, EXC_WAIT. Encoding 2 bits; the unused code recovers to RUN.
- Priority: FLUSH > ME_STALL > state logic.
- FLUSH=1:
  - LD_AG_ME=1 and STALL_DE=0.
  - Next edge: V_ME=0, EXC_ME=0, IDT_PHASE_ME=0, state=RUN. This holds regardless of all other inputs, including mid-IDT sequence.
- ME_STALL=1 (no FLUSH):
  - LD_AG_ME=0; V_ME/EXC_ME/EXC_CODE_ME/IDT_PHASE_ME hold; state holds.
  - STALL_DE=1 if V=1 or state!=RUN, else 0.
- RUN, V=0: LD_AG_ME=1, next V_ME=0, STALL_DE=0.
- RUN, V=1, DEP_STALL=1:
  - LD_AG_ME=1, next V_ME=0 (bubble), STALL_DE=1.
  - DEP_STALL masks SEG_LIMIT_EXC and CS_IDT_RD.
- RUN, V=1, DEP_STALL=0, SEG_LIMIT_EXC=1:
  - LD_AG_ME=1; next V_ME=1, EXC_ME=1, EXC_CODE_ME=SEG_EXC_CODE; state -> EXC_WAIT.
  - STALL_DE=1.
  - SEG_LIMIT_EXC takes priority over CS_IDT_RD.
- RUN, V=1, DEP_STALL=0, CS_IDT_RD=1:
  - LD_AG_ME=1; next V_ME=1, EXC_ME=0, IDT_PHASE_ME=0, EXC_CODE_ME=DE_EXC_CODE_AG; state -> IDT_HI.
  - STALL_DE=1.
- RUN, V=1, no hazard/exception/IDT: LD_AG_ME=1, next V_ME=1, EXC_ME=0, IDT_PHASE_ME=0, STALL_DE=0.
- IDT_HI:
  - LD_AG_ME=1; next V_ME=1, IDT_PHASE_ME=1, EXC_CODE_ME unchanged.
  - State -> RUN; STALL_DE=0, so the next instruction enters AG this edge.
- EXC_WAIT:
  - LD_AG_ME=1, next V_ME=0, EXC_ME=0, STALL_DE=1.
  - Stays in EXC_WAIT until FLUSH; only FLUSH exits.
- STALL_CNT:
  - Increments on every edge where STALL_DE=1, saturating at all-ones.
  - Cleared only by reset.
- Latency: one non-hazard instruction per cycle. An IDT read occupies 2 ME slots. An exception occupies 1 ME slot, then the stage blocks until FLUSH.

Test Plan:
- Reset mid-IDT sequence: assert RST=0 in state IDT_HI -> V_ME=0, IDT_PHASE_ME=0, STALL_CNT=0 immediately (before the next CLK edge); after release, state=RUN.
- Back-to-back: V=1 for 4 cycles, no hazards -> V_ME=1 each cycle, STALL_DE=0 throughout, STALL_CNT=0.
- Dependency: V=1 with DEP_STALL=1 for 3 cycles, then DEP_STALL=0 -> 3 bubbles (V_ME=0), STALL_DE=1 for 3 cycles, STALL_CNT=3; the 4th cycle issues V_ME=1.
- IDT read: V=1, CS_IDT_RD=1, DE_EXC_CODE_AG=4'd8, with ME_STALL=1 in the second cycle -> ME sees phase 0 (code 8); V_ME/IDT_PHASE_ME=0 held one cycle; then phase 1 (code 8); STALL_DE=1 for 2 cycles, then 0.
- Segment fault: V=1, SEG_LIMIT_EXC=1, CS_IDT_RD=1 -> EXC_ME=1, EXC_CODE_ME=13, IDT_PHASE_ME=0; the following 5 cycles give V_ME=0 with STALL_DE=1; FLUSH on cycle 6 -> state RUN and STALL_DE=0.
- Saturation with CNT_W=2: hold DEP_STALL=1 with V=1 for 6 cycles -> STALL_CNT reads 1, 2, 3, 3, 3, 3.
